// File: rtl/sar_controller.sv
`default_nettype none
// ============================================================================
// Module      : sar_controller
// Description : Successive-approximation search controller. Presents a trial
//               code to an external magnitude comparator, decides one bit per
//               step (MSB first) from cmp_lt/cmp_eq and returns the N-bit code.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_controller #(
    parameter int N          = 8,
    parameter int SETTLE     = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    output logic [N-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int c_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_TOP   = c_IDX_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_RELOAD = c_CNT_W'(SETTLE - 1);
    localparam logic [N-1:0]       c_MSB_ONLY  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [N-1:0]         w_decided;   // trial with the current bit resolved
    logic [N-1:0]         w_next_trial; // decided code plus next trial bit set
    logic                 w_eq_exit;

    // Resolve the current bit and prepare the trial for the following step
    always_comb begin
        w_decided          = trial;
        w_decided[r_idx]   = ~cmp_lt;
        w_next_trial       = w_decided;
        if (r_idx != '0) begin
            w_next_trial[r_idx - 1'b1] = 1'b1;
        end
        w_eq_exit = (EARLY_EXIT != 0) && cmp_eq;
    end

    // Search FSM: all outputs registered, done is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            trial   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_idx   <= c_IDX_TOP;
            r_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        trial   <= c_MSB_ONLY;
                        r_idx   <= c_IDX_TOP;
                        r_cnt   <= c_CNT_RELOAD;
                        busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        // Hold the trial until the comparator has settled
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_eq_exit) begin
                        // Exact match: the current trial is the answer
                        result  <= trial;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_idx == '0) begin
                        result  <= w_decided;
                        trial   <= w_decided;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        trial <= w_next_trial;
                        r_idx <= r_idx - 1'b1;
                        r_cnt <= c_CNT_RELOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_controller
// Description : Directed self-checking bench for sar_controller. Three
//               instances (full run, early exit, SETTLE=3) each see an ideal
//               combinational comparator against their own sample value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b, start_c;
    logic [7:0] sample_a, sample_b, sample_c;
    logic [7:0] trial_a, trial_b, trial_c;
    logic [7:0] result_a, result_b, result_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       lt_a, lt_b, lt_c, eq_a, eq_b, eq_c;

    // Ideal comparators: sample < trial and sample == trial
    assign lt_a = (sample_a < trial_a);
    assign eq_a = (sample_a == trial_a);
    assign lt_b = (sample_b < trial_b);
    assign eq_b = (sample_b == trial_b);
    assign lt_c = (sample_c < trial_c);
    assign eq_c = (sample_c == trial_c);

    sar_controller #(.N(8), .SETTLE(1), .EARLY_EXIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cmp_lt(lt_a), .cmp_eq(eq_a),
        .trial(trial_a), .busy(busy_a), .done(done_a), .result(result_a));

    sar_controller #(.N(8), .SETTLE(1), .EARLY_EXIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cmp_lt(lt_b), .cmp_eq(eq_b),
        .trial(trial_b), .busy(busy_b), .done(done_b), .result(result_b));

    sar_controller #(.N(8), .SETTLE(3), .EARLY_EXIT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .cmp_lt(lt_c), .cmp_eq(eq_c),
        .trial(trial_c), .busy(busy_c), .done(done_c), .result(result_c));

    // Hand-derived trial sequence for sample 0x5A
    logic [7:0] seq_5a [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        start_c  = 1'b0;
        sample_a = 8'h00;
        sample_b = 8'h00;
        sample_c = 8'h00;
        tick();
        tick();
        check("rst_trial_a",  trial_a,  8'h00);
        check("rst_result_a", result_a, 8'h00);
        check("rst_busy_a",   busy_a,   1'b0);
        check("rst_done_a",   done_a,   1'b0);
        check("rst_trial_b",  trial_b,  8'h00);
        check("rst_trial_c",  trial_c,  8'h00);
        rst_n = 1'b1;
        tick();
        check("idle_hold_a", trial_a, 8'h00);

        // 1: full run, sample 0x5A
        sample_a = 8'h5A;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        check("t1_first_trial", trial_a, 8'h80);
        check("t1_busy",        busy_a,  1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("t1_trial%0d", i), trial_a, seq_5a[i]);
            check($sformatf("t1_nodone%0d", i), done_a, 1'b0);
        end
        tick();
        check("t1_done",   done_a,   1'b1);
        check("t1_result", result_a, 8'h5A);
        check("t1_busy0",  busy_a,   1'b0);
        check("t1_trial_eq_result", trial_a, 8'h5A);
        tick();
        check("t1_done_pulse", done_a, 1'b0);
        check("t1_result_hold", result_a, 8'h5A);

        // 2: early exit, sample 0x5A
        sample_b = 8'h5A;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        check("t2_first_trial", trial_b, 8'h80);
        for (int i = 1; i < 7; i++) begin
            tick();
            check($sformatf("t2_trial%0d", i), trial_b, seq_5a[i]);
        end
        tick();
        check("t2_done",   done_b,   1'b1);
        check("t2_result", result_b, 8'h5A);
        check("t2_trial",  trial_b,  8'h5A);
        tick();
        check("t2_done_pulse", done_b, 1'b0);

        // 3: 0xFF then 0x00 back-to-back
        sample_a = 8'hFF;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check("t3_nodone_early", done_a, 1'b0);
        tick();
        check("t3_done_ff",   done_a,   1'b1);
        check("t3_result_ff", result_a, 8'hFF);
        sample_a = 8'h00;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        check("t3_done_1cyc", done_a,  1'b0);
        check("t3_restart_busy", busy_a, 1'b1);
        check("t3_restart_trial", trial_a, 8'h80);
        for (int i = 1; i < 8; i++) tick();
        check("t3_nodone2", done_a, 1'b0);
        tick();
        check("t3_done_00",   done_a,   1'b1);
        check("t3_result_00", result_a, 8'h00);
        tick();
        check("t3_done2_1cyc", done_a, 1'b0);

        // 4: SETTLE=3, sample 0x33
        sample_c = 8'h33;
        start_c  = 1'b1;
        tick();
        start_c  = 1'b0;
        check("t4_trial_t0", trial_c, 8'h80);
        tick();
        tick();
        check("t4_trial_hold", trial_c, 8'h80);
        tick();
        check("t4_trial_t3", trial_c, 8'h40);
        tick();
        tick();
        check("t4_trial_hold2", trial_c, 8'h40);
        tick();
        check("t4_trial_t6", trial_c, 8'h20);
        for (int i = 7; i < 24; i++) tick();
        check("t4_nodone_23", done_c, 1'b0);
        tick();
        check("t4_done",   done_c,   1'b1);
        check("t4_result", result_c, 8'h33);

        // 5: start held high throughout a conversion
        sample_a = 8'h5A;
        start_a  = 1'b1;
        tick();
        check("t5_first_trial", trial_a, 8'h80);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("t5_trial%0d", i), trial_a, seq_5a[i]);
        end
        tick();
        check("t5_done",   done_a,   1'b1);
        check("t5_result", result_a, 8'h5A);
        tick();
        check("t5_restart_trial", trial_a, 8'h80);
        check("t5_restart_busy",  busy_a,  1'b1);
        start_a  = 1'b0;
        sample_a = 8'h11;
        for (int i = 1; i < 9; i++) tick();
        check("t5_done_11",   done_a,   1'b1);
        check("t5_result_11", result_a, 8'h11);

        // 6: reset at the 4th decision edge
        sample_a = 8'hC3;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_trial",  trial_a,  8'h00);
        check("t6_rst_result", result_a, 8'h00);
        check("t6_rst_busy",   busy_a,   1'b0);
        check("t6_rst_done",   done_a,   1'b0);
        tick();
        check("t6_no_done", done_a, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t6_fresh_trial", trial_a, 8'h80);
        for (int i = 1; i < 9; i++) tick();
        check("t6_fresh_done",   done_a,   1'b1);
        check("t6_fresh_result", result_a, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
